// File: rtl/audio_dac_serializer.sv
// Stereo DAC serializer: BCLK/LRC generation, one-entry sample buffer, I2S or left-justified output.
// Optional macro VOLUME_EN adds i_vol, an arithmetic right shift applied when a frame is loaded.
module audio_dac_serializer #(
   parameter int SAMPLE_W  = 16,
   parameter int SLOT_W    = 32,
   parameter int BCLK_HALF = 2
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic                i_enb,
   input  logic                i_mode,
   input  logic                i_valid,
   input  logic [SAMPLE_W-1:0] i_left,
   input  logic [SAMPLE_W-1:0] i_right,
`ifdef VOLUME_EN
   input  logic [3:0]          i_vol,
`endif
   output logic                o_ready,
   output logic                o_bclk,
   output logic                o_lrc,
   output logic                o_dat,
   output logic                o_underrun,
   output logic [15:0]         o_underrun_cnt
);

   localparam int BIT_W = $clog2(2 * SLOT_W);
   localparam int DIV_W = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;
   localparam logic [DIV_W-1:0] DIV_ZERO = DIV_W'(0);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_HALF - 1);
   localparam logic [BIT_W-1:0] BIT_ZERO = BIT_W'(0);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(2 * SLOT_W - 1);
   localparam logic [BIT_W-1:0] SLOT_L   = BIT_W'(SLOT_W);

   // Slot image is MSB-aligned; I2S leaves one leading zero before the MSB.
   function automatic logic slot_bit(input logic [SAMPLE_W-1:0] s, input logic m,
                                     input logic [BIT_W-1:0] k);
      logic [SLOT_W-1:0] slot;
      if (m) begin
         slot = SLOT_W'(s) << (SLOT_W - SAMPLE_W);
      end else begin
         slot = SLOT_W'(s) << (SLOT_W - SAMPLE_W - 1);
      end
      slot = slot << k;
      return slot[SLOT_W-1];
   endfunction

`ifdef VOLUME_EN
   function automatic logic [SAMPLE_W-1:0] vol_shift(input logic [SAMPLE_W-1:0] s,
                                                     input logic [3:0] v);
      logic signed [SAMPLE_W-1:0] t;
      t = $signed(s) >>> v;
      return t;
   endfunction
`endif

   logic [DIV_W-1:0]    div_q, div_d;
   logic                bclk_q, bclk_d;
   logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
   logic                lrc_q, lrc_d;
   logic                dat_q, dat_d;
   logic [SAMPLE_W-1:0] hold_l_q, hold_l_d, hold_r_q, hold_r_d;
   logic                empty_q, empty_d;
   logic [SAMPLE_W-1:0] shift_l_q, shift_l_d, shift_r_q, shift_r_d;
   logic                mode_q, mode_d;
   logic                urun_q, urun_d;
   logic [15:0]         urun_cnt_q, urun_cnt_d;
   logic                fall_s;
   logic                accept_s;
   logic [BIT_W-1:0]    k_s;
   logic [SAMPLE_W-1:0] load_l_s, load_r_s;

`ifdef VOLUME_EN
   assign load_l_s = vol_shift(hold_l_q, i_vol);
   assign load_r_s = vol_shift(hold_r_q, i_vol);
`else
   assign load_l_s = hold_l_q;
   assign load_r_s = hold_r_q;
`endif

   // Next-state: BCLK divider, bit sequencing, frame load/underrun and the holding-buffer handshake.
   always_comb begin
      div_d      = div_q;
      bclk_d     = bclk_q;
      bit_cnt_d  = bit_cnt_q;
      lrc_d      = lrc_q;
      dat_d      = dat_q;
      hold_l_d   = hold_l_q;
      hold_r_d   = hold_r_q;
      empty_d    = empty_q;
      shift_l_d  = shift_l_q;
      shift_r_d  = shift_r_q;
      mode_d     = mode_q;
      urun_d     = 1'b0;
      urun_cnt_d = urun_cnt_q;
      fall_s     = 1'b0;
      accept_s   = i_valid & empty_q;
      if (bit_cnt_q >= SLOT_L) begin
         k_s = bit_cnt_q - SLOT_L;
      end else begin
         k_s = bit_cnt_q;
      end

      if (!i_enb) begin
         div_d     = DIV_ZERO;
         bclk_d    = 1'b0;
         bit_cnt_d = BIT_ZERO;
         lrc_d     = 1'b0;
         dat_d     = 1'b0;
      end else if (div_q == DIV_LAST) begin
         div_d  = DIV_ZERO;
         bclk_d = ~bclk_q;
         fall_s = bclk_q;
      end else begin
         div_d = div_q + DIV_W'(1);
      end

      if (fall_s) begin
         // Bit 0 is the frame boundary: the buffer state before this edge decides transfer vs underrun.
         if (bit_cnt_q == BIT_ZERO) begin
            mode_d = i_mode;
            if (empty_q) begin
               shift_l_d = {SAMPLE_W{1'b0}};
               shift_r_d = {SAMPLE_W{1'b0}};
               urun_d    = 1'b1;
               if (urun_cnt_q != 16'hFFFF) begin
                  urun_cnt_d = urun_cnt_q + 16'd1;
               end else begin
                  urun_cnt_d = urun_cnt_q;
               end
            end else begin
               shift_l_d = load_l_s;
               shift_r_d = load_r_s;
               empty_d   = 1'b1;
            end
         end else begin
            mode_d = mode_q;
         end
         if (bit_cnt_q == BIT_LAST) begin
            bit_cnt_d = BIT_ZERO;
         end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
         end
         lrc_d = (bit_cnt_q >= SLOT_L);
         dat_d = slot_bit(lrc_d ? shift_r_d : shift_l_d, mode_d, k_s);
      end else begin
         lrc_d = (i_enb) ? lrc_q : 1'b0;
      end

      if (accept_s) begin
         hold_l_d = i_left;
         hold_r_d = i_right;
         empty_d  = 1'b0;
      end else begin
         hold_l_d = hold_l_q;
         hold_r_d = hold_r_q;
      end
   end

   // State register with synchronous reset.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         div_q      <= DIV_ZERO;
         bclk_q     <= 1'b0;
         bit_cnt_q  <= BIT_ZERO;
         lrc_q      <= 1'b0;
         dat_q      <= 1'b0;
         hold_l_q   <= {SAMPLE_W{1'b0}};
         hold_r_q   <= {SAMPLE_W{1'b0}};
         empty_q    <= 1'b1;
         shift_l_q  <= {SAMPLE_W{1'b0}};
         shift_r_q  <= {SAMPLE_W{1'b0}};
         mode_q     <= 1'b0;
         urun_q     <= 1'b0;
         urun_cnt_q <= 16'd0;
      end else begin
         div_q      <= div_d;
         bclk_q     <= bclk_d;
         bit_cnt_q  <= bit_cnt_d;
         lrc_q      <= lrc_d;
         dat_q      <= dat_d;
         hold_l_q   <= hold_l_d;
         hold_r_q   <= hold_r_d;
         empty_q    <= empty_d;
         shift_l_q  <= shift_l_d;
         shift_r_q  <= shift_r_d;
         mode_q     <= mode_d;
         urun_q     <= urun_d;
         urun_cnt_q <= urun_cnt_d;
      end
   end

   assign o_ready        = empty_q;
   assign o_bclk         = bclk_q;
   assign o_lrc          = lrc_q;
   assign o_dat          = dat_q;
   assign o_underrun     = urun_q;
   assign o_underrun_cnt = urun_cnt_q;

endmodule

// File: tb/tb_audio_dac_serializer.sv
// Self-checking bench: cycle-accurate frame model built from BCLK/frame arithmetic plus literal frame checks.
module tb_audio_dac_serializer;

   localparam int SW   = 16;
   localparam int SLOT = 32;
   localparam int BH   = 2;

   logic        clk;
   logic        i_rst, i_enb, i_mode, i_valid;
   logic [15:0] i_left, i_right;
`ifdef VOLUME_EN
   logic [3:0]  i_vol;
`endif
   logic        o_ready, o_bclk, o_lrc, o_dat, o_underrun;
   logic [15:0] o_underrun_cnt;

   audio_dac_serializer #(.SAMPLE_W(SW), .SLOT_W(SLOT), .BCLK_HALF(BH)) dut (
      .i_clk(clk), .i_rst(i_rst), .i_enb(i_enb), .i_mode(i_mode), .i_valid(i_valid),
      .i_left(i_left), .i_right(i_right),
`ifdef VOLUME_EN
      .i_vol(i_vol),
`endif
      .o_ready(o_ready), .o_bclk(o_bclk), .o_lrc(o_lrc), .o_dat(o_dat),
      .o_underrun(o_underrun), .o_underrun_cnt(o_underrun_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_tests = 0;
   int n_fail  = 0;

   // Reference state: buffer, enabled-edge count, current frame contents.
   bit          m_empty = 1'b1;
   int          m_n = 0;
   int          m_cnt = 0;
   int          m_b = 0;
   bit          m_bclk, m_lrc, m_dat, m_urun, m_fall, m_acc, m_fmode;
   logic [15:0] m_hl, m_hr, m_fl, m_fr;
   logic [31:0] cap_l = 32'd0, cap_r = 32'd0;
   int          urun_seen = 0;
   int          s = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   function automatic logic model_bit(input logic [15:0] smp, input bit md, input int k);
      logic [15:0] t;
      if (md) begin
         if (k >= SW) return 1'b0;
         t = smp >> (SW - 1 - k);
      end else begin
         if (k < 1 || k > SW) return 1'b0;
         t = smp >> (SW - k);
      end
      return t[0];
   endfunction

   function automatic logic [15:0] m_load(input logic [15:0] smp);
`ifdef VOLUME_EN
      int v;
      v = int'($signed(smp));
      for (int i = 0; i < int'(i_vol); i++) v = (v < 0) ? -((-v + 1) / 2) : v / 2;
      return 16'(v);
`else
      return smp;
`endif
   endfunction

   // Advance the model by the posedge just passed, using the inputs that were present at it.
   task automatic model_step();
      bit pre_empty;
      m_acc  = 1'b0;
      m_fall = 1'b0;
      m_urun = 1'b0;
      if (i_rst) begin
         m_empty = 1'b1; m_n = 0; m_cnt = 0;
         m_bclk = 1'b0; m_lrc = 1'b0; m_dat = 1'b0;
         m_fl = 16'd0; m_fr = 16'd0; m_fmode = 1'b0;
      end else begin
         pre_empty = m_empty;
         m_acc = i_valid && pre_empty;
         if (!i_enb) begin
            m_n = 0; m_bclk = 1'b0; m_lrc = 1'b0; m_dat = 1'b0;
         end else begin
            m_n++;
            m_bclk = ((m_n / BH) % 2) == 1;
            if (m_n % (2 * BH) == 0) begin
               m_fall = 1'b1;
               m_b = (m_n / (2 * BH) - 1) % (2 * SLOT);
               if (m_b == 0) begin
                  m_fmode = i_mode;
                  if (!pre_empty) begin
                     m_fl = m_load(m_hl); m_fr = m_load(m_hr); m_empty = 1'b1;
                  end else begin
                     m_fl = 16'd0; m_fr = 16'd0; m_urun = 1'b1;
                     if (m_cnt < 65535) m_cnt++;
                  end
               end
               m_lrc = (m_b >= SLOT);
               m_dat = model_bit(m_lrc ? m_fr : m_fl, m_fmode, m_b % SLOT);
            end
         end
         if (m_acc) begin
            m_hl = i_left; m_hr = i_right; m_empty = 1'b0;
         end
      end
   endtask

   // Per-cycle compare against the model, plus capture of each slot's bits as seen on the pins.
   initial begin
      forever begin
         @(negedge clk);
         model_step();
         check("ready",    32'(o_ready),        32'(m_empty));
         check("bclk",     32'(o_bclk),         32'(m_bclk));
         check("lrc",      32'(o_lrc),          32'(m_lrc));
         check("dat",      32'(o_dat),          32'(m_dat));
         check("underrun", 32'(o_underrun),     32'(m_urun));
         check("urun_cnt", 32'(o_underrun_cnt), 32'(m_cnt));
         if (o_underrun === 1'b1) urun_seen++;
         if (m_fall) begin
            if (m_b == 0) begin
               cap_l = 32'd0; cap_r = 32'd0;
            end
            if (o_lrc === 1'b1) cap_r = {cap_r[30:0], o_dat};
            else                cap_l = {cap_l[30:0], o_dat};
         end
      end
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic run_to(input int t);
      while (s < t) begin
         step();
         s++;
      end
   endtask

   int  acc;
   int  k;
   bit  rdy;
   bit  prev;

   initial begin
      i_rst = 1'b1; i_enb = 1'b0; i_mode = 1'b0; i_valid = 1'b0;
      i_left = 16'd0; i_right = 16'd0;
`ifdef VOLUME_EN
      i_vol = 4'd0;
`endif
      repeat (3) step();
      check("rst_ready", 32'(o_ready), 32'd1);
      check("rst_bclk",  32'(o_bclk),  32'd0);
      check("rst_cnt",   32'(o_underrun_cnt), 32'd0);
      i_rst = 1'b0;

      // I2S frame from a pre-filled buffer, then underrun, then refill, then a left-justified frame.
      i_valid = 1'b1; i_left = 16'hA5C3; i_right = 16'h0001;
      step();
      i_valid = 1'b0;
      i_enb = 1'b1; s = 0;
      run_to(256);
      check("i2s_left",  cap_l, 32'h52E18000);
      check("i2s_right", cap_r, 32'h00008000);
      run_to(300);
      i_valid = 1'b1; i_left = 16'h7FFF; i_right = 16'h8000;
      run_to(301);
      i_valid = 1'b0;
      run_to(512);
      check("urun_left",  cap_l, 32'h0);
      check("urun_right", cap_r, 32'h0);
      check("urun_cnt1",  32'(o_underrun_cnt), 32'd1);
      run_to(600);
      i_mode = 1'b1;
      i_valid = 1'b1; i_left = 16'hA5C3; i_right = 16'h0001;
      run_to(601);
      i_valid = 1'b0;
      run_to(768);
      check("refill_left",  cap_l, 32'h3FFF8000);
      check("refill_right", cap_r, 32'h40000000);
      check("refill_cnt",   32'(o_underrun_cnt), 32'd1);
      run_to(1024);
      check("lj_left",  cap_l, 32'hA5C30000);
      check("lj_right", cap_r, 32'h00010000);
      check("pulses",   32'(urun_seen), 32'd1);

      // Back-pressure: one acceptance per frame over ten frames, no underrun.
      acc = 0;
      i_valid = 1'b1; i_left = 16'($urandom); i_right = 16'($urandom);
      while (s < 3590) begin
         rdy = o_ready;
         run_to(s + 1);
         if (rdy) begin
            if (s > 1030) acc++;
            i_left = 16'($urandom); i_right = 16'($urandom);
         end
      end
      i_valid = 1'b0;
      check("bp_accepts", 32'(acc), 32'd10);
      check("bp_cnt",     32'(o_underrun_cnt), 32'd1);

      // Disable with a full buffer: pins idle, count held.
      i_enb = 1'b0;
      repeat (30) step();
      check("dis_ready", 32'(o_ready), 32'd0);
      check("dis_bclk",  32'(o_bclk),  32'd0);
      check("dis_cnt",   32'(o_underrun_cnt), 32'd1);

      // Reset in the middle of a frame, then first fall four cycles after release.
      i_enb = 1'b1;
      repeat (104) step();
      i_rst = 1'b1;
      step();
      check("mid_rst_ready", 32'(o_ready), 32'd1);
      check("mid_rst_lrc",   32'(o_lrc),   32'd0);
      check("mid_rst_dat",   32'(o_dat),   32'd0);
      check("mid_rst_cnt",   32'(o_underrun_cnt), 32'd0);
      i_rst = 1'b0;
      prev = o_bclk;
      k = 0;
      while (k < 20) begin
         step();
         k++;
         if (prev && !o_bclk) break;
         prev = o_bclk;
      end
      check("first_fall", 32'(k), 32'd4);

      // Randomised traffic, mode flips, enable toggles and occasional resets.
      for (int i = 0; i < 6000; i++) begin
         i_valid = ($urandom_range(0, 2) == 0);
         i_left  = 16'($urandom);
         i_right = 16'($urandom);
         if ($urandom_range(0, 299) == 0) i_mode = ~i_mode;
         if ($urandom_range(0, 799) == 0) i_enb = ~i_enb;
         i_rst = ($urandom_range(0, 2999) == 0);
         step();
      end
      i_rst = 1'b0; i_enb = 1'b1;

`ifdef VOLUME_EN
      i_rst = 1'b1; step(); i_rst = 1'b0;
      i_vol = 4'd2; i_mode = 1'b1;
      i_valid = 1'b1; i_left = 16'h8000; i_right = 16'h1234;
      step();
      i_valid = 1'b0;
      s = 0;
      run_to(256);
      check("vol2_left",  cap_l, 32'hE0000000);
      check("vol2_right", cap_r, 32'h048D0000);
      run_to(300);
      i_vol = 4'd15;
      i_valid = 1'b1; i_left = 16'h1234; i_right = 16'h8000;
      run_to(301);
      i_valid = 1'b0;
      run_to(768);
      check("vol15_left",  cap_l, 32'h00000000);
      check("vol15_right", cap_r, 32'hFFFF0000);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/audio_dac_serializer.md
Name: audio_dac_serializer

Overview:
Parametrised stereo DAC serializer, the successor to the fixed 16-bit audio interface in the audio player.
- Generates BCLK and LRC internally from i_clk.
- Accepts left/right sample pairs over a valid/ready handshake through a one-entry holding buffer.
- Serialises samples MSB-first in I2S or left-justified format, selectable at runtime.
- Sits between the sample memory/reader and the codec DAC pins.
- Detects and counts buffer underruns.

Parameters:
- SAMPLE_W, 16, bits per channel sample (8..24).
- SLOT_W, 32, BCLK periods per channel slot; must be >= SAMPLE_W+1.
- BCLK_HALF, 2, i_clk cycles per BCLK half-period (>= 1).

Ports:
- i_clk  in  1  system clock (codec MCLK domain)
- i_rst  in  1  synchronous active-high reset
- i_enb  in  1  run enable; low = idle
- i_mode  in  1  0 = I2S (1-BCLK MSB delay), 1 = left-justified
- i_valid  in  1  sample pair valid
- i_left  in  SAMPLE_W  left sample, two's complement
- i_right  in  SAMPLE_W  right sample, two's complement
- o_ready  out  1  holding buffer empty, pair accepted on i_valid & o_ready
- o_bclk  out  1  bit clock to DAC
- o_lrc  out  1  frame clock; 0 = left slot, 1 = right slot
- o_dat  out  1  serial data
- o_underrun  out  1  one-cycle pulse on underrun
- o_underrun_cnt  out  16  saturating underrun count

Behaviour:
- Reset values: all outputs 0 except o_ready=1. Holding buffer empty. Shift register 0. Counters 0. Latched mode 0.
- All outputs are registered.
- Reset mid-frame: all of the above apply on the next edge; no partial frame completes.
- i_enb low (sync): o_bclk, o_lrc and o_dat forced 0; divider and bit counter cleared.
  - Handshake stays active while disabled, so the holding buffer can be pre-filled.
  - o_underrun_cnt holds its value.
- Divider: counts 0..BCLK_HALF-1; o_bclk toggles on wrap.
  - First rising edge of o_bclk comes BCLK_HALF cycles after i_enb rises.
  - "fall" = cycle in which o_bclk goes 1->0.
- Bit counter: 0..2*SLOT_W-1, advanced at each fall; wraps to 0.
  - After enable, the first fall loads bit 0 of the frame (frame boundary).
- At each fall, o_lrc = (bit_cnt >= SLOT_W) and o_dat = current slot bit.
  - Data changes only on BCLK falling edges; the DAC samples on rising edges.
- Bit placement within a slot, with slot bit index k:
  - mode 1: MSB at k=0, LSB at k=SAMPLE_W-1.
  - mode 0: k=0 carries 0, MSB at k=1, LSB at k=SAMPLE_W.
  - All remaining slot bits are 0.
- i_mode is sampled at the frame boundary; a mid-frame change takes effect on the next frame.
- Frame boundary, holding buffer full: the pair transfers to the shift register and the buffer empties, so o_ready=1 the next cycle.
- Frame boundary, holding buffer empty (underrun):
  - The frame is sent as all zeros.
  - o_underrun pulses 1 cycle.
  - o_underrun_cnt increments, saturating at 0xFFFF.
- Simultaneous accept and frame boundary: the transfer uses the buffer state before that edge.
  - An empty buffer still underruns on that boundary.
  - The newly accepted pair is stored and used at the next boundary.
  - A full buffer transfers and cannot accept on the same cycle (o_ready=0).
- i_valid while o_ready=0: ignored; the sender must hold the pair.
- Throughput: one pair per 2*SLOT_W*2*BCLK_HALF cycles.

Optional Feature:
VOLUME_EN
- Defined: adds port i_vol (in, 4 bits).
  - Each sample is arithmetic-right-shifted by i_vol (sign preserved) when loaded into the shift register.
  - i_vol >= SAMPLE_W yields 0 or -1 according to the sample sign.
  - i_vol is sampled at the frame boundary.
- Undefined: no i_vol port; samples are sent unmodified.

Test Plan:
Defaults SAMPLE_W=16, SLOT_W=32, BCLK_HALF=2, giving a 256-cycle frame.
- I2S: pre-fill L=0xA5C3, R=0x0001, mode 0, enable -> left slot bits 0..16 = 0,1010010111000011, rest 0; right slot bit 16 = 1, rest 0; o_lrc low 128 cycles then high 128; o_dat changes only on o_bclk falls.
- Left-justified: same pair, mode 1 -> left slot bits 0..15 = 0xA5C3 MSB-first; right slot bit 15 = 1.
- Underrun: one pair, then no i_valid -> second frame all zeros, o_underrun pulses once, o_underrun_cnt=1; feed 0x7FFF/0x8000 mid-frame -> sent next frame, no further increment.
- Back-pressure: hold i_valid=1 with a new pair each acceptance -> exactly one acceptance per frame; o_ready=0 from accept to the following boundary; no underrun over 10 frames.
- Reset mid-frame: assert i_rst at cycle 100 of a frame -> next cycle outputs 0, o_ready=1, o_underrun_cnt=0; after release, the frame restarts from bit 0 with the first fall at cycle 4 after release.
- VOLUME_EN: i_vol=2, L=0x8000 -> sent 0xE000; i_vol=15, L=0x1234 -> sent 0x0000.
